// File: rtl/backscatter_switch_sequencer.sv
// backscatter_switch_sequencer
//  Registered driver for the tag's RF switch bank. A frame runs
//  IDLE -> TONE (masked square-wave preamble) -> DATA (masked words, each
//  held for a programmable number of cycles) -> IDLE. Every output comes
//  straight from a flop, so the switch pins never see combinational glitches.
//  Optional feature macro: SWITCH_DEADTIME_EN (break-before-make between
//  differing back-to-back data symbols).
//
//  Data handshake (valid/ready): a word transfers on a rising edge where
//  data_valid and data_ready are both 1. The source holds data_in/data_last
//  stable while data_valid is high and not yet accepted. data_ready is
//  registered, and it depends only on sequencer state, never on data_valid.
//  data_in is ignored on any cycle without a transfer.
module backscatter_switch_sequencer #(
  parameter int NUM_SWITCHES = 20,
  parameter int DIV_WIDTH    = 8,
  parameter int LEN_WIDTH    = 16
) (
  input  logic                    input_clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    abort,
  input  logic [NUM_SWITCHES-1:0] control_mask,
  input  logic [DIV_WIDTH-1:0]    tone_half_period,
  input  logic [LEN_WIDTH-1:0]    preamble_cycles,
  input  logic [LEN_WIDTH-1:0]    symbol_cycles,
  input  logic                    data_valid,
  input  logic [NUM_SWITCHES-1:0] data_in,
  input  logic                    data_last,
  output logic                    data_ready,
  output logic [NUM_SWITCHES-1:0] out_signal_switch,
  output logic                    busy,
  output logic                    done,
  output logic                    underrun,
  output logic [1:0]              dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_TONE = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  state_t                  state_q;
  logic [NUM_SWITCHES-1:0] mask_q;
  logic [DIV_WIDTH-1:0]    thp_load_q;    // max(half_period,1)-1
  logic [LEN_WIDTH-1:0]    sym_load_q;    // max(symbol_cycles,1)-1
  logic [LEN_WIDTH-1:0]    pre_cnt_q;     // TONE cycles remaining after this one
  logic [DIV_WIDTH-1:0]    div_cnt_q;     // cycles until next phase toggle
  logic                    phase_q;
  logic [LEN_WIDTH-1:0]    sym_cnt_q;     // hold cycles remaining after this one
  logic                    sym_active_q;  // a data symbol is on the pins
  logic                    last_acc_q;    // the data_last word has been taken
  logic [NUM_SWITCHES-1:0] word_q;        // masked word of the current symbol
  logic [NUM_SWITCHES-1:0] out_q;
  logic                    ready_q;
  logic                    busy_q;
  logic                    done_q;
  logic                    underrun_q;

  logic [DIV_WIDTH-1:0]    thp_load_in;
  logic [LEN_WIDTH-1:0]    sym_load_in;
  logic [LEN_WIDTH-1:0]    pre_load_in;
  logic [LEN_WIDTH-1:0]    sym_cnt_dec;
  logic [NUM_SWITCHES-1:0] masked_in;
  logic                    handshake;
  logic                    sym_final;
  logic                    dead;

  // Decode zero-means-one settings, the transfer strobe and symbol boundary.
  always_comb begin
    thp_load_in = (tone_half_period == '0) ? '0 : tone_half_period - DIV_WIDTH'(1);
    sym_load_in = (symbol_cycles == '0) ? '0 : symbol_cycles - LEN_WIDTH'(1);
    pre_load_in = preamble_cycles - LEN_WIDTH'(1);
    sym_cnt_dec = sym_cnt_q - LEN_WIDTH'(1);
    masked_in   = mask_q & data_in;
    handshake   = (state_q == ST_DATA) && data_valid && ready_q;
    sym_final   = sym_active_q && (sym_cnt_q == '0);
`ifdef SWITCH_DEADTIME_EN
    // Blank the first cycle of a back-to-back symbol whose pattern differs.
    // After TONE or an underrun the pins already sit at 0 while ready waits,
    // so only symbol-to-symbol boundaries can need the extra break.
    dead        = sym_final && (sym_load_q != '0) && (masked_in != word_q);
`else
    dead        = 1'b0;
`endif
  end

  // Frame sequencer: state, counters and all registered outputs.
  always_ff @(posedge input_clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      mask_q       <= '0;
      thp_load_q   <= '0;
      sym_load_q   <= '0;
      pre_cnt_q    <= '0;
      div_cnt_q    <= '0;
      phase_q      <= 1'b0;
      sym_cnt_q    <= '0;
      sym_active_q <= 1'b0;
      last_acc_q   <= 1'b0;
      word_q       <= '0;
      out_q        <= '0;
      ready_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      underrun_q   <= 1'b0;
    end else if (abort) begin
      state_q      <= ST_IDLE;
      phase_q      <= 1'b0;
      sym_active_q <= 1'b0;
      last_acc_q   <= 1'b0;
      out_q        <= '0;
      ready_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      underrun_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          out_q   <= '0;
          ready_q <= 1'b0;
          busy_q  <= 1'b0;
          if (start) begin
            mask_q       <= control_mask;
            thp_load_q   <= thp_load_in;
            sym_load_q   <= sym_load_in;
            sym_cnt_q    <= '0;
            sym_active_q <= 1'b0;
            last_acc_q   <= 1'b0;
            busy_q       <= 1'b1;
            if (preamble_cycles == '0) begin
              state_q <= ST_DATA;
              ready_q <= 1'b1;
            end else begin
              // Divider restarts here; first tone cycle has phase 1.
              state_q   <= ST_TONE;
              pre_cnt_q <= pre_load_in;
              div_cnt_q <= thp_load_in;
              phase_q   <= 1'b1;
              out_q     <= control_mask;
            end
          end
        end

        ST_TONE: begin
          if (pre_cnt_q == '0) begin
            state_q      <= ST_DATA;
            out_q        <= '0;
            ready_q      <= 1'b1;
            sym_active_q <= 1'b0;
          end else begin
            pre_cnt_q <= pre_cnt_q - LEN_WIDTH'(1);
            if (div_cnt_q == '0) begin
              phase_q   <= ~phase_q;
              div_cnt_q <= thp_load_q;
              out_q     <= mask_q & {NUM_SWITCHES{~phase_q}};
            end else begin
              div_cnt_q <= div_cnt_q - DIV_WIDTH'(1);
              out_q     <= mask_q & {NUM_SWITCHES{phase_q}};
            end
          end
        end

        ST_DATA: begin
          if (handshake) begin
            sym_active_q <= 1'b1;
            sym_cnt_q    <= sym_load_q;
            last_acc_q   <= data_last;
            word_q       <= masked_in;
            out_q        <= dead ? '0 : masked_in;
            ready_q      <= (sym_load_q == '0) && !data_last;
          end else if (sym_final) begin
            sym_active_q <= 1'b0;
            out_q        <= '0;
            if (last_acc_q) begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              ready_q <= 1'b0;
            end else begin
              underrun_q <= 1'b1;
              ready_q    <= 1'b1;
            end
          end else if (sym_active_q) begin
            sym_cnt_q <= sym_cnt_dec;
            out_q     <= word_q;
            ready_q   <= (sym_cnt_dec == '0) && !last_acc_q;
          end else begin
            // Waiting for a word (after entry or after an underrun).
            out_q   <= '0;
            ready_q <= 1'b1;
          end
        end

        default: begin
          state_q <= ST_IDLE;
          out_q   <= '0;
          ready_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign data_ready        = ready_q;
  assign out_signal_switch = out_q;
  assign busy              = busy_q;
  assign done              = done_q;
  assign underrun          = underrun_q;
  assign dbg_state         = state_q;

endmodule

// File: tb/tb_backscatter_switch_sequencer.sv
// Bench for backscatter_switch_sequencer: a frame-level model expands each
// frame description into a per-cycle expected trace, a driver plays the
// frame, and a monitor compares every cycle against the expected queue.
module tb_backscatter_switch_sequencer;
  localparam int N  = 20;
  localparam int DW = 8;
  localparam int LW = 16;
  localparam int EW = 32 + N + 4;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic          reset, start, abort, data_valid, data_last;
  logic [N-1:0]  control_mask, data_in;
  logic [DW-1:0] tone_half_period;
  logic [LW-1:0] preamble_cycles, symbol_cycles;
  logic          data_ready, busy, done, underrun;
  logic [N-1:0]  out_signal_switch;
  logic [1:0]    dbg_state;

  backscatter_switch_sequencer #(.NUM_SWITCHES(N), .DIV_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .input_clock(clk), .reset(reset), .start(start), .abort(abort),
    .control_mask(control_mask), .tone_half_period(tone_half_period),
    .preamble_cycles(preamble_cycles), .symbol_cycles(symbol_cycles),
    .data_valid(data_valid), .data_in(data_in), .data_last(data_last),
    .data_ready(data_ready), .out_signal_switch(out_signal_switch),
    .busy(busy), .done(done), .underrun(underrun), .dbg_state(dbg_state)
  );

  // scoreboard: {cycle, out, ready, busy, done, underrun}
  logic [EW-1:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  // frame description
  logic [N-1:0] f_mask;
  logic [N-1:0] f_word [16];
  int f_gap [16];
  int f_p, f_thp, f_sym, f_n, f_g0, f_kind, f_kat, f_len, f_done;

  // per-relative-cycle expected trace
  logic [N-1:0] eo [256];
  bit er [256], eb [256], ed [256], eu [256];

  task automatic set_c(input int c, input logic [N-1:0] o, input bit r,
                       input bit b, input bit d, input bit u);
    eo[c] = o; er[c] = r; eb[c] = b; ed[c] = d; eu[c] = u;
  endtask

  // Expand the frame into cycles from acceptance times: a word whose valid
  // rises at v is taken at the first ready cycle at or after v.
  task automatic model_frame(input int base);
    int t, s, a, v, na, c;
    bit dt, dt_next;
    logic [N-1:0] mw;
    t = (f_thp == 0) ? 1 : f_thp;
    s = (f_sym == 0) ? 1 : f_sym;
    for (c = 0; c < f_p; c++)
      set_c(c, (((c / t) % 2) == 0) ? f_mask : '0, 0, 1, 0, 0);
    a = (f_g0 > f_p) ? f_g0 : f_p;
    for (c = f_p; c <= a; c++) set_c(c, '0, 1, 1, 0, 0);
    dt = 0;
    for (int k = 0; k < f_n; k++) begin
      mw = f_mask & f_word[k];
      for (int j = 1; j <= s; j++)
        set_c(a + j, (j == 1 && dt) ? '0 : mw, (j == s) && (k != f_n - 1), 1, 0, 0);
      if (k == f_n - 1) begin
        f_done = a + s + 1;
        set_c(f_done, '0, 0, 0, 1, 0);
      end else begin
        v = a + 1 + f_gap[k + 1];
        if (v <= a + s) begin
          dt_next = (s >= 2) && ((f_mask & f_word[k + 1]) != mw);
          na = a + s;
        end else begin
          dt_next = 0;
          set_c(a + s + 1, '0, 1, 1, 0, 1);
          for (c = a + s + 2; c <= v; c++) set_c(c, '0, 1, 1, 0, 0);
          na = v;
        end
`ifndef SWITCH_DEADTIME_EN
        dt_next = 0;
`endif
        dt = dt_next;
        a = na;
      end
    end
    f_len = f_done + 3;
    for (c = f_done + 1; c < f_len; c++) set_c(c, '0, 0, 0, 0, 0);
    if (f_kind != 0) begin
      if (f_kat > f_done - 1) f_kat = f_done - 1;
      for (c = f_kat + 1; c < f_len; c++) set_c(c, '0, 0, 0, 0, 0);
    end
    for (c = 0; c < f_len; c++)
      exp_q.push_back({base + c, eo[c], er[c], eb[c], ed[c], eu[c]});
  endtask

  // driver: start the frame, then stream words with the planned gaps
  task automatic run_frame();
    int base, k, cnt;
    bit vld, rdy_prev, stop;
    @(negedge clk);
    base = cyc + 1;
    model_frame(base);
    control_mask = f_mask;
    tone_half_period = DW'(f_thp);
    preamble_cycles = LW'(f_p);
    symbol_cycles = LW'(f_sym);
    start = 1'b1;
    data_valid = 1'b0;
    k = 0; cnt = f_g0; vld = 0; rdy_prev = 0; stop = 0;
    for (int c = 0; c < f_len; c++) begin
      @(negedge clk);
      if (vld && rdy_prev && !stop) begin
        k++;
        if (k < f_n) cnt = f_gap[k];
      end
      if (f_kind != 0 && c > f_kat) stop = 1;
      start = (c < f_done) && (f_kind == 0 || c <= f_kat) && ($urandom_range(0, 3) == 0);
      abort = (f_kind == 1) && (c == f_kat);
      reset = (f_kind == 2) && (c == f_kat || c == f_kat + 1);
      control_mask = N'($urandom);
      tone_half_period = DW'($urandom);
      preamble_cycles = LW'($urandom_range(0, 9));
      symbol_cycles = LW'($urandom_range(0, 9));
      if (k < f_n && !stop) begin
        if (cnt == 0) vld = 1;
        else begin vld = 0; cnt--; end
      end else vld = 0;
      data_valid = vld;
      data_in = vld ? f_word[k] : N'($urandom);
      data_last = vld ? (k == f_n - 1) : 1'($urandom_range(0, 1));
      rdy_prev = data_ready;
    end
    start = 1'b0; abort = 1'b0; reset = 1'b0; data_valid = 1'b0;
  endtask

  task automatic plan(input int p, input int thp, input int sym, input int n,
                      input logic [N-1:0] mask, input int g0, input int kind, input int kat);
    f_p = p; f_thp = thp; f_sym = sym; f_n = n; f_mask = mask;
    f_g0 = g0; f_kind = kind; f_kat = kat;
    for (int i = 0; i < 16; i++) begin
      f_word[i] = N'($urandom);
      f_gap[i] = 0;
    end
  endtask

  // monitor: compare every cycle that has an expected entry
  logic [EW-1:0] mon_e;
  logic [N+3:0]  mon_act;
  always @(negedge clk) begin
    while (exp_q.size() > 0 && int'(exp_q[0][EW-1 -: 32]) < cyc) begin
      mon_e = exp_q.pop_front();
      n_cmp++; n_bad++;
      $display("FAIL missed_cycle %0d: entry never sampled (now cycle %0d)", int'(mon_e[EW-1 -: 32]), cyc);
    end
    if (exp_q.size() > 0 && int'(exp_q[0][EW-1 -: 32]) == cyc) begin
      mon_e = exp_q.pop_front();
      mon_act = {out_signal_switch, data_ready, busy, done, underrun};
      n_cmp++;
      if (mon_act !== mon_e[N+3:0]) begin
        n_bad++;
        $display("FAIL cycle_%0d out/ready/busy/done/underrun: got %h/%b%b%b%b want %h/%b%b%b%b",
                 cyc, mon_act[N+3:4], mon_act[3], mon_act[2], mon_act[1], mon_act[0],
                 mon_e[N+3:4], mon_e[3], mon_e[2], mon_e[1], mon_e[0]);
      end
    end
  end

  initial begin
    int r, b;
    reset = 1'b1; start = 1'b0; abort = 1'b0; data_valid = 1'b0; data_last = 1'b0;
    control_mask = '0; data_in = '0; tone_half_period = '0;
    preamble_cycles = '0; symbol_cycles = '0;
    for (int c = 1; c <= 3; c++) exp_q.push_back({c, {N{1'b0}}, 4'b0000});
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // tone pattern: mask 1011, half period 2, 8 tone cycles
    plan(8, 2, 1, 1, N'(4'b1011), 8, 0, 0);
    run_frame();
    // no preamble, three words held 3 cycles, always valid
    plan(0, 1, 3, 3, N'($urandom), 0, 0, 0);
    run_frame();
    // underrun: valid dropped after word A, symbol of 2
    plan(0, 1, 2, 2, N'($urandom), 0, 0, 0);
    f_gap[1] = 3;
    run_frame();
    // abort on the fourth tone cycle
    plan(10, 3, 2, 2, N'($urandom), 0, 1, 3);
    run_frame();
    // abort together with start while idle
    @(negedge clk);
    b = cyc + 1;
    start = 1'b1; abort = 1'b1; preamble_cycles = LW'(5); symbol_cycles = LW'(2);
    control_mask = '1;
    for (int c = 0; c < 3; c++) exp_q.push_back({b + c, {N{1'b0}}, 4'b0000});
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    repeat (2) @(negedge clk);
    // reset held two cycles in the middle of DATA
    plan(2, 1, 3, 4, N'($urandom), 0, 2, 6);
    run_frame();
    // differing and identical back-to-back words, symbol of 4
    plan(0, 1, 4, 2, N'(4'hF), 0, 0, 0);
    f_word[0] = N'(4'b1010); f_word[1] = N'(4'b0101);
    run_frame();
    plan(0, 1, 4, 2, N'(4'hF), 0, 0, 0);
    f_word[0] = N'(4'b1010); f_word[1] = N'(4'b1010);
    run_frame();

    // randomized frames
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 7);
      plan($urandom_range(0, 12), $urandom_range(0, 4), $urandom_range(0, 4),
           $urandom_range(1, 6), N'($urandom), $urandom_range(0, 15),
           (r == 0) ? 1 : ((r == 1) ? 2 : 0), $urandom_range(0, 40));
      for (int k = 1; k < 16; k++) f_gap[k] = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 6) : 0;
      run_frame();
    end

    for (int w = 0; w < 50 && exp_q.size() > 0; w++) @(negedge clk);
    if (exp_q.size() > 0) begin
      n_cmp++; n_bad++;
      $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
